// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_stage_if #(parameter int XLEN = 32);
   logic            in_valid_i;
   logic            in_ready_o;
   logic [31:0]     in_instr_i;
   logic [XLEN-1:0] in_pc_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] out_pc_o;
   logic [31:0]     out_instr_o;
   logic [4:0]      out_rd_o;
   logic [4:0]      out_rs1_o;
   logic [4:0]      out_rs2_o;
   logic [2:0]      out_funct3_o;
   logic [XLEN-1:0] out_imm_o;
   logic [1:0]      out_aluop_o;
   logic            out_alu_use_imm_o;
   logic            out_reg_wb_o;
   logic            out_reg_lui_o;
   logic            out_is_auipc_o;
   logic            out_branch_o;
   logic            out_mem_read_o;
   logic            out_mem_write_o;
   logic            out_mem_to_reg_o;
   logic [1:0]      out_jump_o;
   logic            out_is_word_o;
   logic            out_ecall_o;
   logic            out_ebreak_o;
   logic            out_fence_o;
   logic            out_illegal_o;

   modport slave (
      input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_rd_o, out_rs1_o, out_rs2_o,
             out_funct3_o, out_imm_o, out_aluop_o, out_alu_use_imm_o, out_reg_wb_o,
             out_reg_lui_o, out_is_auipc_o, out_branch_o, out_mem_read_o, out_mem_write_o,
             out_mem_to_reg_o, out_jump_o, out_is_word_o, out_ecall_o, out_ebreak_o,
             out_fence_o, out_illegal_o
   );

   modport master (
      output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_rd_o, out_rs1_o, out_rs2_o,
             out_funct3_o, out_imm_o, out_aluop_o, out_alu_use_imm_o, out_reg_wb_o,
             out_reg_lui_o, out_is_auipc_o, out_branch_o, out_mem_read_o, out_mem_write_o,
             out_mem_to_reg_o, out_jump_o, out_is_word_o, out_ecall_o, out_ebreak_o,
             out_fence_o, out_illegal_o
   );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I/RV64I decode stage with output register and one-entry skid buffer
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   decode_stage_if.slave bus
);
   localparam bit IS_RV32 = (XLEN == 32);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [XLEN-1:0] imm;
      logic [1:0]      aluop;
      logic            alu_use_imm;
      logic            reg_wb;
      logic            reg_lui;
      logic            is_auipc;
      logic            branch;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic [1:0]      jump;
      logic            is_word;
      logic            ecall;
      logic            ebreak;
      logic            fence;
      logic            illegal;
   } entry_t;

   entry_t      dec;
   entry_t      o_q, o_d, s_q, s_d;
   logic        o_valid_q, o_valid_d, s_valid_q, s_valid_d;
   logic [31:0] ins;
   logic [31:0] imm32;
   logic        ill;
   logic        in_fire, out_fire;

   assign ins = bus.in_instr_i;

   always_comb begin
      dec        = '0;
      imm32      = '0;
      ill        = 1'b0;
      dec.pc     = bus.in_pc_i;
      dec.instr  = ins;
      dec.rd     = ins[11:7];
      dec.rs1    = ins[19:15];
      dec.rs2    = ins[24:20];
      dec.funct3 = ins[14:12];
      case (ins[6:0])
         7'b0110011, 7'b0111011: begin
            dec.aluop   = 2'd3;
            dec.reg_wb  = 1'b1;
            dec.is_word = ins[3];
            ill         = ins[3] && IS_RV32;
         end
         7'b0010011, 7'b0011011: begin
            dec.aluop       = 2'd3;
            dec.alu_use_imm = 1'b1;
            dec.reg_wb      = 1'b1;
            dec.is_word     = ins[3];
            imm32           = {{20{ins[31]}}, ins[31:20]};
            // On RV32 a shift amount of 32..63 is not encodable.
            ill = IS_RV32 && (ins[3] || (ins[13:12] == 2'b01 && ins[25]));
         end
         7'b0000011: begin
            dec.alu_use_imm = 1'b1;
            dec.reg_wb      = 1'b1;
            dec.mem_read    = 1'b1;
            dec.mem_to_reg  = 1'b1;
            imm32           = {{20{ins[31]}}, ins[31:20]};
         end
         7'b0100011: begin
            dec.alu_use_imm = 1'b1;
            dec.mem_write   = 1'b1;
            imm32           = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         end
         7'b1100011: begin
            dec.aluop  = 2'd2;
            dec.branch = 1'b1;
            imm32      = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         7'b1101111: begin
            dec.jump   = 2'b01;
            dec.reg_wb = 1'b1;
            imm32      = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         7'b1100111: begin
            dec.jump        = 2'b10;
            dec.reg_wb      = 1'b1;
            dec.alu_use_imm = 1'b1;
            imm32           = {{20{ins[31]}}, ins[31:20]};
         end
         7'b0110111, 7'b0010111: begin
            dec.reg_lui     = ins[5];
            dec.is_auipc    = !ins[5];
            dec.reg_wb      = 1'b1;
            dec.alu_use_imm = 1'b1;
            imm32           = {ins[31:12], 12'b0};
         end
         7'b0001111: dec.fence = 1'b1;
         7'b1110011: begin
            dec.ecall  = (ins == 32'h0000_0073);
            dec.ebreak = (ins == 32'h0010_0073);
            ill        = !(dec.ecall || dec.ebreak);
         end
         default: ill = 1'b1;
      endcase
      if (ins[1:0] != 2'b11) ill = 1'b1;
      dec.imm = XLEN'($signed(imm32));
      // Illegal entries still travel so the trap logic sees the PC, but must have no side effects.
      if (ill) begin
         dec.reg_wb    = 1'b0;
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 2'b00;
         dec.ecall     = 1'b0;
         dec.ebreak    = 1'b0;
         dec.fence     = 1'b0;
      end
      dec.illegal = ill;
   end

   assign in_fire  = bus.in_valid_i && !s_valid_q;
   assign out_fire = o_valid_q && bus.out_ready_i;

   always_comb begin
      o_d       = o_q;
      s_d       = s_q;
      o_valid_d = o_valid_q;
      s_valid_d = s_valid_q;
      if (flush_i) begin
         o_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!o_valid_q || out_fire) begin
         if (s_valid_q) begin
            o_d       = s_q;
            s_valid_d = 1'b0;
         end else if (in_fire) begin
            o_d       = dec;
            o_valid_d = 1'b1;
         end else begin
            o_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         s_d       = dec;
         s_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         o_q       <= '0;
         s_q       <= '0;
         o_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
      end else begin
         o_q       <= o_d;
         s_q       <= s_d;
         o_valid_q <= o_valid_d;
         s_valid_q <= s_valid_d;
      end
   end

   assign bus.in_ready_o        = !s_valid_q;
   assign bus.out_valid_o       = o_valid_q;
   assign bus.out_pc_o          = o_q.pc;
   assign bus.out_instr_o       = o_q.instr;
   assign bus.out_rd_o          = o_q.rd;
   assign bus.out_rs1_o         = o_q.rs1;
   assign bus.out_rs2_o         = o_q.rs2;
   assign bus.out_funct3_o      = o_q.funct3;
   assign bus.out_imm_o         = o_q.imm;
   assign bus.out_aluop_o       = o_q.aluop;
   assign bus.out_alu_use_imm_o = o_q.alu_use_imm;
   assign bus.out_reg_wb_o      = o_q.reg_wb;
   assign bus.out_reg_lui_o     = o_q.reg_lui;
   assign bus.out_is_auipc_o    = o_q.is_auipc;
   assign bus.out_branch_o      = o_q.branch;
   assign bus.out_mem_read_o    = o_q.mem_read;
   assign bus.out_mem_write_o   = o_q.mem_write;
   assign bus.out_mem_to_reg_o  = o_q.mem_to_reg;
   assign bus.out_jump_o        = o_q.jump;
   assign bus.out_is_word_o     = o_q.is_word;
   assign bus.out_ecall_o       = o_q.ecall;
   assign bus.out_ebreak_o      = o_q.ebreak;
   assign bus.out_fence_o       = o_q.fence;
   assign bus.out_illegal_o     = o_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed checks of decode_stage at XLEN=32 and XLEN=64 side by side
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [63:0] in_pc = '0;
   logic        out_ready = 1'b1;
   int          n_total = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) b32 ();
   decode_stage_if #(.XLEN(64)) b64 ();

   assign b32.in_valid_i  = in_valid;
   assign b32.in_instr_i  = in_instr;
   assign b32.in_pc_i     = in_pc[31:0];
   assign b32.out_ready_i = out_ready;
   assign b64.in_valid_i  = in_valid;
   assign b64.in_instr_i  = in_instr;
   assign b64.in_pc_i     = in_pc;
   assign b64.out_ready_i = out_ready;

   decode_stage #(.XLEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .bus(b32));
   decode_stage #(.XLEN(64)) dut64 (.clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .bus(b64));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic issue(input logic [31:0] ins, input logic [63:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      #1 rst_ni = 1'b0;
      #2;
      check("rst_out_valid", b32.out_valid_o, 0);
      check("rst_in_ready", b32.in_ready_o, 1);
      check("rst_imm", b64.out_imm_o, 0);
      check("rst_instr", b32.out_instr_o, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);

      issue(32'h0050_0093, 64'h100);
      check("addi_valid", b32.out_valid_o, 1);
      check("addi_imm", b32.out_imm_o, 5);
      check("addi_rd", b32.out_rd_o, 1);
      check("addi_aluop", b32.out_aluop_o, 3);
      check("addi_use_imm", b32.out_alu_use_imm_o, 1);
      check("addi_wb", b32.out_reg_wb_o, 1);
      check("addi_illegal", b32.out_illegal_o, 0);
      check("addi_pc", b32.out_pc_o, 64'h100);

      issue(32'h8000_0137, 64'h104);
      check("lui_imm64", b64.out_imm_o, 64'hFFFF_FFFF_8000_0000);
      check("lui_imm32", b32.out_imm_o, 64'h8000_0000);
      check("lui_flag", b64.out_reg_lui_o, 1);

      issue(32'hFE00_0EE3, 64'h108);
      check("beq_imm", b32.out_imm_o, 64'hFFFF_FFFC);
      check("beq_branch", b32.out_branch_o, 1);
      check("beq_aluop", b32.out_aluop_o, 2);

      issue(32'h0020_A223, 64'h10C);
      check("sw_imm", b64.out_imm_o, 4);
      check("sw_mem_write", b64.out_mem_write_o, 1);
      check("sw_wb", b64.out_reg_wb_o, 0);

      issue(32'h0000_0000, 64'h110);
      check("zero_illegal", b32.out_illegal_o, 1);
      check("zero_wb", b32.out_reg_wb_o, 0);

      issue(32'h0000_003B, 64'h114);
      check("addw32_illegal", b32.out_illegal_o, 1);
      check("addw32_wb", b32.out_reg_wb_o, 0);
      check("addw64_illegal", b64.out_illegal_o, 0);
      check("addw64_word", b64.out_is_word_o, 1);
      check("addw64_wb", b64.out_reg_wb_o, 1);

      issue(32'h0200_9093, 64'h118);
      check("slli32_illegal", b32.out_illegal_o, 1);
      check("slli64_illegal", b64.out_illegal_o, 0);

      issue(32'h0000_0073, 64'h11C);
      check("ecall", b32.out_ecall_o, 1);
      check("ecall_illegal", b32.out_illegal_o, 0);
      issue(32'h0010_0073, 64'h120);
      check("ebreak", b32.out_ebreak_o, 1);
      check("ebreak_ecall", b32.out_ecall_o, 0);
      issue(32'h0FF0_000F, 64'h124);
      check("fence", b32.out_fence_o, 1);
      check("fence_wb", b32.out_reg_wb_o, 0);
      issue(32'h3000_2073, 64'h128);
      check("csrr_illegal", b32.out_illegal_o, 1);
      check("csrr_ecall", b32.out_ecall_o, 0);
      idle(1);
      check("drain_valid", b32.out_valid_o, 0);

      // Stall: A to O, B to S, C refused; release drains in order.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0010_0093;
      in_pc     = 64'h200;
      @(posedge clk); @(negedge clk);
      check("stall_ready_a", b32.in_ready_o, 1);
      in_instr = 32'h0020_0113;
      in_pc    = 64'h204;
      @(posedge clk); @(negedge clk);
      check("stall_ready_b", b32.in_ready_o, 0);
      in_instr = 32'h0030_0193;
      in_pc    = 64'h208;
      @(posedge clk); @(negedge clk);
      check("stall_ready_c", b32.in_ready_o, 0);
      check("stall_hold_a", b32.out_instr_o, 32'h0010_0093);
      check("stall_hold_imm", b32.out_imm_o, 1);
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("order_b", b32.out_instr_o, 32'h0020_0113);
      check("order_b_ready", b32.in_ready_o, 1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check("order_c", b32.out_instr_o, 32'h0030_0193);
      check("order_c_pc", b64.out_pc_o, 64'h208);
      check("order_c_valid", b32.out_valid_o, 1);
      idle(1);
      check("order_empty", b32.out_valid_o, 0);

      // Flush with only O held while a new input is accepted.
      out_ready = 1'b0;
      issue(32'h0040_0213, 64'h300);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h0050_0293;
      check("flush1_cur_valid", b32.out_valid_o, 1);
      @(posedge clk); @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush1_valid", b32.out_valid_o, 0);
      check("flush1_ready", b32.in_ready_o, 1);

      // Flush with O and S both full.
      issue(32'h0060_0313, 64'h310);
      issue(32'h0070_0393, 64'h314);
      check("flush2_full", b32.in_ready_o, 0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h0080_0413;
      @(posedge clk); @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("flush2_valid", b32.out_valid_o, 0);
      check("flush2_ready", b32.in_ready_o, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("flush2_no_stale", b32.out_valid_o, 0);
      end

      // Throughput: back-to-back entries with no bubble.
      in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_instr = {12'(i), 20'h00093};
         in_pc    = 64'h400 + 64'(4 * i);
         @(posedge clk); @(negedge clk);
         check("tput_imm", b32.out_imm_o, 64'(i));
         check("tput_valid", b32.out_valid_o, 1);
      end
      in_valid = 1'b0;

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      issue(32'h0050_0093, 64'h500);
      issue(32'h0060_0093, 64'h504);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_valid", b32.out_valid_o, 0);
      check("arst_ready", b32.in_ready_o, 1);
      check("arst_imm", b64.out_imm_o, 0);
      check("arst_wb", b32.out_reg_wb_o, 0);
      @(negedge clk);
      rst_ni = 1'b1;
      idle(2);
      check("arst_after", b32.out_valid_o, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage. Sits between fetch and execute. Decodes one RV32I/RV64I instruction per cycle into XLEN-wide immediates and control signals, and carries them through an output register plus a one-entry skid buffer under valid/ready handshakes. Adds three things earlier decode logic lacks: flush, illegal-instruction detection, and SYSTEM/FENCE classification.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64. With 64, OP-32 and OP-IMM-32 (W-ops) decode as legal.
- clk_i  in  1  clock; every register updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous kill of all held entries.
- in_valid_i  in  1  upstream has an instruction.
- in_ready_o  out  1  stage can accept; equals !skid_valid (registered, no combinational path from out_ready_i).
- in_instr_i  in  32  instruction word.
- in_pc_i  in  XLEN  instruction PC; passed through unchanged.
- out_valid_o  out  1  decoded entry available.
- out_ready_i  in  1  downstream accepts.
- out_pc_o  out  XLEN; out_instr_o  out  32; out_rd_o, out_rs1_o, out_rs2_o  out  5 each; out_funct3_o  out  3.
- out_imm_o  out  XLEN  sign-extended immediate.
- out_aluop_o  out  2  encodings: Add=0, Sleft=1, Branch=2, Funct=3.
- out_alu_use_imm_o, out_reg_wb_o, out_reg_lui_o, out_is_auipc_o, out_branch_o, out_mem_read_o, out_mem_write_o, out_mem_to_reg_o  out  1 each.
- out_jump_o  out  2  values: 00 none, 01 JAL, 10 JALR.
- out_is_word_o  out  1  W-op (OP-32 / OP-IMM-32).
- out_ecall_o, out_ebreak_o, out_fence_o  out  1 each.
- out_illegal_o  out  1  instruction is illegal.

## Operation
- Decode is combinational on in_instr_i. The result is captured into the output register (O) or the skid register (S) when in_valid_i && in_ready_o.
- Control per opcode:
  - OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC follow the established control mapping. The I/S/B/U/J immediates are sign-extended from bit 31 to XLEN.
  - U-imm is {instr[31:12], 12'b0}, then sign-extended.
- OP-32 (0111011) and OP-IMM-32 (0011011) decode as OP/OP-IMM and set out_is_word_o.
- MISC-MEM (0001111) sets out_fence_o; all other controls are 0.
- SYSTEM:
  - 0x00000073 sets out_ecall_o.
  - 0x00100073 sets out_ebreak_o.
  - Any other SYSTEM encoding (CSR ops) is illegal.
- Illegal when any of:
  - instr[1:0] != 2'b11;
  - unlisted opcode;
  - W-op with XLEN=32;
  - SLLI/SRLI/SRAI with instr[25]=1 when XLEN=32;
  - SYSTEM other than ECALL/EBREAK.
- For an illegal entry: out_illegal_o=1, and reg_wb, mem_read, mem_write, branch, jump, ecall, ebreak and fence are all forced to 0. The entry still flows through so the PC reaches the trap logic.
- Buffer control, evaluated each cycle when there is no flush:
  - If !O.valid or O fires (out_valid_o && out_ready_i):
    - if S.valid: O<=S, S.valid<=0;
    - else if input fires: O<=new;
    - else O.valid<=0.
  - Else, if input fires: S<=new.
- Program order is always preserved.
- flush_i=1: O.valid<=0 and S.valid<=0 next edge. Any input accepted that same cycle is discarded. out_valid_o still reflects the current O during the flush cycle.

## Timing
- Reset, asynchronous: O.valid=S.valid=0, so out_valid_o=0 and in_ready_o=1. All out_* payload outputs are 0. Reset mid-transfer drops every held entry.
- Latency: accept at edge N gives out_valid_o high from N+1.
- Throughput: 1 instruction per cycle while out_ready_i=1.
- Stall: with out_ready_i=0, two instructions are accepted (O, then S), after which in_ready_o=0. When out_ready_i returns to 1, in_ready_o returns to 1 one cycle later (S drains into O).
- Simultaneous output fire and input fire with S empty: the new entry goes to O, with no bubble.
- Payload outputs hold stable while out_valid_o && !out_ready_i.

## Test plan
- Reset, then 0x00500093 (addi x1,x0,5) -> next cycle out_valid_o=1, imm=5, rd=1, aluop=3, alu_use_imm=1, reg_wb=1, illegal=0.
- XLEN=64, 0x80000137 (lui x2,0x80000) -> imm=0xFFFFFFFF80000000, reg_lui=1. Same word with XLEN=32 -> 0x80000000.
- Hold out_ready_i=0 and offer 3 instructions -> 2 accepted, in_ready_o=0. Release -> outputs appear in order A, B, C at one per cycle after the drain.
- 0x00000000 -> illegal=1, reg_wb=0. 0x0000003B (addw) with XLEN=32 -> illegal=1. Same with XLEN=64 -> is_word=1, illegal=0.
- Fill O and S, then assert flush_i together with in_valid_i -> next cycle out_valid_o=0 and in_ready_o=1, and no stale entry ever appears.
- 0x00000073 -> ecall=1. 0x00100073 -> ebreak=1. 0x0FF0000F -> fence=1. 0x30002073 (csrr) -> illegal=1. Assert rst_ni low mid-stream -> outputs go to 0 immediately.
